c3lib_tie_mon_1x: RTL
=====================

# c3lib_tie_mon_1x

Receive-side monitor for tie-off and strap nets driven by tie-low/tie-high cells. Synchronizes a multi-bit static input and waits a settle window after enable. It then flags, via a sticky error with per-bit capture, any sustained deviation from the expected tie value. It sits at the consuming end of configuration straps, e.g. adapter mode pins and redundancy tie-offs, as a DFT/safety observer.

## Interface
- WIDTH, 4: number of monitored tie bits (1..32).
- EXP_VAL, '0: expected static value, WIDTH bits.
- SYNC_STAGES, 2: synchronizer flop depth (2..4).
- SETTLE_CYCLES, 16: cycles ignored after enable before checking (>=1).
- FILT_CYCLES, 4: consecutive mismatch cycles required to flag (>=1).

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
- din  input  WIDTH  tie/strap nets; asynchronous to clk.
- chk_en  input  1  monitor enable (level).
- clr_err  input  1  single-cycle pulse; clears sticky error state.
- mon_val  output  WIDTH  synchronized din.
- settled  output  1  high while in MON state.
- err  output  1  sticky deviation flag.
- err_bits  output  WIDTH  sticky OR of mismatching bits.

## Operation
- Reset values: mon_val=0, settled=0, err=0, err_bits=0, state=IDLE, counters=0.
- mismatch[i] = mon_val[i] ^ EXP_VAL[i]; any_mm = |mismatch.
- States: IDLE, SETTLE, MON, ERR.
- IDLE:
  - On chk_en=1, go to SETTLE with settle_cnt=0.
- SETTLE:
  - settle_cnt increments each cycle.
  - Mismatches are ignored.
  - After SETTLE_CYCLES cycles in SETTLE, go to MON with filt_cnt=0.
- MON:
  - filt_cnt increments while any_mm=1; it returns to 0 on any cycle with any_mm=0.
  - When any_mm=1 and filt_cnt==FILT_CYCLES-1: next edge sets err=1, ORs mismatch into err_bits, and goes to ERR.
- ERR:
  - err holds 1.
  - err_bits keeps OR-accumulating raw, unfiltered mismatch every cycle.
- chk_en=0 in any state: go to IDLE next edge and clear counters. err/err_bits are retained.
- clr_err=1: next edge sets err=0 and err_bits=0. If in ERR or MON with chk_en=1, go to SETTLE with settle_cnt=0.
- Simultaneous events:
  - clr_err with a same-cycle filter hit: clear wins, and the block restarts SETTLE.
  - chk_en=0 with clr_err: both take effect (IDLE, errors cleared).
- Counter widths are $clog2(max+1). Counters saturate and never wrap.
- Reset mid-operation: all state returns to reset values immediately (async). No error is preserved.

## Timing
- din to mon_val: SYNC_STAGES edges.
- chk_en rise to settled=1: SETTLE_CYCLES+1 edges (1 edge into SETTLE, SETTLE_CYCLES in SETTLE).
- First mismatched mon_val sample in MON to err=1: FILT_CYCLES edges.
- din change to err: SYNC_STAGES+FILT_CYCLES edges.
- clr_err to err=0: 1 edge.
- All outputs are registered. No combinational input-to-output paths.

## Structure
- Package c3lib_tie_mon_pkg holds:
  - the state enum (tie_mon_state_e: IDLE, SETTLE, MON, ERR, 2-bit);
  - counter-width helper functions;
  - parameter-range check constants.
- Sub-module c3lib_tie_mon_sync: WIDTH-wide, SYNC_STAGES-deep async-reset flop synchronizer, reset value 0, marked for hardening like other c3lib primitives.
- The top level holds the FSM, the settle/filter counters and the sticky registers.
- Elaboration-time assertions enforce the parameter ranges.

## Test plan
- Defaults, din=4'b0000 held; rst_n release; chk_en=1 at cycle 0 -> settled=1 at cycle 17, err=0 for 1000 cycles.
- In MON, din=4'b0100 held -> mon_val=4'b0100 after 2 edges, err=1 and err_bits=4'b0100 exactly 6 edges after the din change.
- In MON, din[1] glitch high for 3 cycles then low -> err stays 0 and filt_cnt returns to 0. A 4-cycle pulse sets err=1, err_bits=4'b0010.
- din=4'b1000 during SETTLE only, cleared before settled -> no error. Then in ERR with din=4'b0001 after a 4'b0100 flag -> err_bits accumulates to 4'b0101. clr_err -> err=0, err_bits=0, settled=0 for 16 cycles.
- clr_err on the same cycle as a filter hit -> err stays 0 and the state is SETTLE. chk_en=0 while err=1 -> IDLE, err remains 1 until clr_err.
- rst_n asserted mid-MON with filt_cnt=2 -> all outputs 0 asynchronously. After release, a full settle is required before any flag.

Source files
------------

// File: rtl/c3lib_tie_mon_pkg.sv
// Shared types and helpers for the tie-off / strap monitor.
package c3lib_tie_mon_pkg;

    // Monitor FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        MON    = 2'd2,
        ERR    = 2'd3
    } tie_mon_state_e;

    // Legal parameter ranges, checked at elaboration in the top level.
    localparam int TIE_MON_WIDTH_MIN  = 1;
    localparam int TIE_MON_WIDTH_MAX  = 32;
    localparam int TIE_MON_SYNC_MIN   = 2;
    localparam int TIE_MON_SYNC_MAX   = 4;
    localparam int TIE_MON_SETTLE_MIN = 1;
    localparam int TIE_MON_FILT_MIN   = 1;

    // Bits needed to hold a counter that runs from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/c3lib_tie_mon_sync.sv
// Multi-bit flop-chain synchronizer for quasi-static tie/strap nets.
// Hardened c3lib primitive: the stages form a pure flop chain with no
// logic between them, so they must be kept together and not retimed.
module c3lib_tie_mon_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign data_o = sync_q[STAGES-1];

endmodule

// File: rtl/c3lib_tie_mon_1x.sv
// Receive-side tie-off monitor: synchronizes the strap nets, waits a settle
// window after enable, then flags any sustained deviation from EXP_VAL with
// a sticky error and per-bit capture of the offending bits.
module c3lib_tie_mon_1x
    import c3lib_tie_mon_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] EXP_VAL       = '0,
    parameter int               SYNC_STAGES   = 2,
    parameter int               SETTLE_CYCLES = 16,
    parameter int               FILT_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             chk_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] mon_val,
    output logic             settled,
    output logic             err,
    output logic [WIDTH-1:0] err_bits,
    output tie_mon_state_e   dbg_state
);

    localparam int SCW = cnt_width(SETTLE_CYCLES);
    localparam int FCW = cnt_width(FILT_CYCLES);

    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [SCW-1:0] SETTLE_MAX  = SCW'(SETTLE_CYCLES);
    localparam logic [FCW-1:0] FILT_LAST   = FCW'(FILT_CYCLES - 1);
    localparam logic [FCW-1:0] FILT_MAX    = FCW'(FILT_CYCLES);

    // Reject out-of-range parameters at elaboration.
    if (WIDTH < TIE_MON_WIDTH_MIN || WIDTH > TIE_MON_WIDTH_MAX) begin : g_bad_width
        $error("c3lib_tie_mon_1x: WIDTH must be in 1..32");
    end
    if (SYNC_STAGES < TIE_MON_SYNC_MIN || SYNC_STAGES > TIE_MON_SYNC_MAX) begin : g_bad_sync
        $error("c3lib_tie_mon_1x: SYNC_STAGES must be in 2..4");
    end
    if (SETTLE_CYCLES < TIE_MON_SETTLE_MIN) begin : g_bad_settle
        $error("c3lib_tie_mon_1x: SETTLE_CYCLES must be >= 1");
    end
    if (FILT_CYCLES < TIE_MON_FILT_MIN) begin : g_bad_filt
        $error("c3lib_tie_mon_1x: FILT_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] mismatch;
    logic             any_mm;

    tie_mon_state_e   state_q,      state_d;
    logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [FCW-1:0]   filt_cnt_q,   filt_cnt_d;
    logic             err_q,        err_d;
    logic [WIDTH-1:0] err_bits_q,   err_bits_d;
    logic             settled_q;

    c3lib_tie_mon_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (din),
        .data_o (sync_val)
    );

    // Compare the synchronized straps against the expected tie value.
    always_comb begin
        mismatch = sync_val ^ EXP_VAL;
        any_mm   = |mismatch;
    end

    // Next-state logic: disable beats clear, clear beats a same-cycle filter hit.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        filt_cnt_d   = filt_cnt_q;
        err_d        = err_q;
        err_bits_d   = err_bits_q;

        if (!chk_en) begin
            state_d      = IDLE;
            settle_cnt_d = '0;
            filt_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
                SETTLE: begin
                    if (settle_cnt_q != SETTLE_MAX) begin
                        settle_cnt_d = settle_cnt_q + SCW'(1);
                    end
                    if (settle_cnt_q >= SETTLE_LAST) begin
                        state_d    = MON;
                        filt_cnt_d = '0;
                    end
                end
                MON: begin
                    if (any_mm) begin
                        if (filt_cnt_q >= FILT_LAST) begin
                            state_d    = ERR;
                            err_d      = 1'b1;
                            err_bits_d = err_bits_q | mismatch;
                        end
                        if (filt_cnt_q != FILT_MAX) begin
                            filt_cnt_d = filt_cnt_q + FCW'(1);
                        end
                    end else begin
                        filt_cnt_d = '0;
                    end
                end
                ERR: begin
                    // Keep capturing every raw mismatch once flagged.
                    err_bits_d = err_bits_q | mismatch;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (clr_err) begin
            err_d      = 1'b0;
            err_bits_d = '0;
            if (chk_en && (state_q == MON || state_q == ERR)) begin
                state_d      = SETTLE;
                settle_cnt_d = '0;
                filt_cnt_d   = '0;
            end
        end
    end

    // FSM, counters and sticky registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            filt_cnt_q   <= '0;
            err_q        <= 1'b0;
            err_bits_q   <= '0;
            settled_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            filt_cnt_q   <= filt_cnt_d;
            err_q        <= err_d;
            err_bits_q   <= err_bits_d;
            settled_q    <= (state_d == MON);
        end
    end

    assign mon_val   = sync_val;
    assign settled   = settled_q;
    assign err       = err_q;
    assign err_bits  = err_bits_q;
    assign dbg_state = state_q;

endmodule
